pipe_seq_ctrl: RTL and testbench

//  Front-end sequencer: owns the stage enables for fetch (if_en) and decode (id_en).

---
 rtl/pipe_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_seq_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_seq_ctrl.sv
// rtl/pipe_seq_ctrl.sv - front-end sequencer: table clear sweep, fetch warm-up, flush/drain control
module pipe_seq_ctrl #(
    parameter int  INIT_DEPTH        = 32,
    parameter int  FETCH_TO_ID_DELAY = 2,
    parameter int  DRAIN_CYCLES      = 4,
    localparam int IDX_W   = (INIT_DEPTH > 1) ? $clog2(INIT_DEPTH) : 1,
    localparam int MAX_CNT = (FETCH_TO_ID_DELAY > DRAIN_CYCLES) ? FETCH_TO_ID_DELAY : DRAIN_CYCLES,
    localparam int CNT_W   = $clog2(MAX_CNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_req,
    input  logic             rob_empty,
    output logic             init_we,
    output logic [IDX_W-1:0] init_addr,
    output logic             if_en,
    output logic             id_en,
    output logic             flush,
    output logic             busy,
    output logic             ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WARM,
        S_RUN,
        S_FLUSH,
        S_DRAIN
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(INIT_DEPTH - 1);
    localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(FETCH_TO_ID_DELAY - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    state_t           r_state, w_next_state;
    logic [IDX_W-1:0] r_idx, w_next_idx;
    logic [CNT_W-1:0] r_cnt, w_next_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_next_state = S_INIT;
                w_next_idx   = '0;
                w_next_cnt   = '0;
            end
            S_INIT: begin
                // flush_req is deliberately not looked at: nothing is fetching yet
                if (r_idx == LAST_IDX) begin
                    w_next_state = S_WARM;
                    w_next_cnt   = '0;
                end else begin
                    w_next_idx = r_idx + IDX_W'(1);
                end
            end
            S_WARM: begin
                if (flush_req) begin
                    w_next_state = S_FLUSH;
                    w_next_cnt   = '0;
                end else if (r_cnt >= WARM_LAST) begin
                    w_next_state = S_RUN;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (flush_req) begin
                    w_next_state = S_FLUSH;
                    w_next_cnt   = '0;
                end
            end
            S_FLUSH: begin
                w_next_state = flush_req ? S_FLUSH : S_DRAIN;
                w_next_cnt   = '0;
            end
            S_DRAIN: begin
                // a new flush beats the exit; the count saturates while waiting on the ROB
                if (flush_req) begin
                    w_next_state = S_FLUSH;
                    w_next_cnt   = '0;
                end else if ((r_cnt >= DRAIN_LAST) && rob_empty) begin
                    w_next_state = S_WARM;
                    w_next_cnt   = '0;
                end else if (r_cnt < DRAIN_LAST) begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_idx   = '0;
                w_next_cnt   = '0;
            end
        endcase
    end

    assign init_we   = (r_state == S_INIT);
    assign init_addr = (r_state == S_INIT) ? r_idx : '0;
    assign if_en     = (r_state == S_WARM) || (r_state == S_RUN);
    assign id_en     = (r_state == S_RUN);
    assign flush     = (r_state == S_FLUSH);
    assign busy      = (r_state == S_INIT) || (r_state == S_FLUSH) || (r_state == S_DRAIN);
    assign ready     = (r_state == S_RUN);

    a_id_needs_if: assert property (@(posedge clk) id_en |-> if_en);
    a_flush_quiet: assert property (@(posedge clk) flush |-> (!if_en && !id_en));
    a_we_in_init:  assert property (@(posedge clk) init_we |-> (r_state == S_INIT));

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// tb/tb_pipe_seq_ctrl.sv - directed vector bench for pipe_seq_ctrl
module tb_pipe_seq_ctrl;

    localparam int ST_IDLE  = 0;
    localparam int ST_INIT  = 1;
    localparam int ST_WARM  = 2;
    localparam int ST_RUN   = 3;
    localparam int ST_FLUSH = 4;
    localparam int ST_DRAIN = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush_req = 1'b0;
    logic       rob_empty = 1'b0;
    logic       init_we;
    logic [1:0] init_addr;
    logic       if_en, id_en, flush, busy, ready;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic rst;
        logic fr;
        logic re;
        int   st;
        int   addr;
    } vec_t;

    vec_t vecs[$];

    pipe_seq_ctrl #(
        .INIT_DEPTH       (4),
        .FETCH_TO_ID_DELAY(2),
        .DRAIN_CYCLES     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush_req(flush_req),
        .rob_empty(rob_empty),
        .init_we  (init_we),
        .init_addr(init_addr),
        .if_en    (if_en),
        .id_en    (id_en),
        .flush    (flush),
        .busy     (busy),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    // {init_we, init_addr[1:0], if_en, id_en, flush, busy, ready}
    function automatic logic [7:0] expect_outs(input int st, input int addr);
        logic [1:0] a;
        a = addr[1:0];
        case (st)
            ST_INIT:  return {1'b1, a, 5'b00010};
            ST_WARM:  return 8'b000_10000;
            ST_RUN:   return 8'b000_11001;
            ST_FLUSH: return 8'b000_00110;
            ST_DRAIN: return 8'b000_00010;
            default:  return 8'b0;
        endcase
    endfunction

    task automatic add(input logic r, input logic f, input logic e, input int st, input int addr);
        vec_t v;
        v.rst = r; v.fr = f; v.re = e; v.st = st; v.addr = addr;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    initial begin
        int first_if;
        int first_id;
        logic [7:0] got;

        // reset holds everything at zero
        for (int i = 0; i < 5; i++) add(1, 0, 0, ST_IDLE, 0);
        // T1: sweep 0..3, two WARM cycles, then RUN
        add(0, 0, 0, ST_INIT, 0);
        add(0, 0, 0, ST_INIT, 1);
        add(0, 0, 0, ST_INIT, 2);
        add(0, 0, 0, ST_INIT, 3);
        add(0, 0, 0, ST_WARM, 0);
        add(0, 0, 0, ST_WARM, 0);
        add(0, 0, 0, ST_RUN, 0);
        add(0, 0, 0, ST_RUN, 0);
        // T2: flush, ROB busy for 6 cycles
        add(0, 1, 0, ST_FLUSH, 0);
        for (int i = 0; i < 6; i++) add(0, 0, 0, ST_DRAIN, 0);
        add(0, 0, 1, ST_WARM, 0);
        add(0, 0, 0, ST_WARM, 0);
        add(0, 0, 0, ST_RUN, 0);
        // T3: ROB already empty -> exactly 4 DRAIN cycles
        add(0, 1, 1, ST_FLUSH, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 1, ST_DRAIN, 0);
        add(0, 0, 1, ST_WARM, 0);
        add(0, 0, 1, ST_WARM, 0);
        add(0, 0, 1, ST_RUN, 0);
        // T5: re-flush in DRAIN cycle 2, then a long ROB wait exercising count saturation
        add(0, 1, 0, ST_FLUSH, 0);
        add(0, 0, 0, ST_DRAIN, 0);
        add(0, 0, 0, ST_DRAIN, 0);
        add(0, 1, 1, ST_FLUSH, 0);
        for (int i = 0; i < 9; i++) add(0, 0, 0, ST_DRAIN, 0);
        add(0, 0, 1, ST_WARM, 0);
        add(0, 0, 0, ST_WARM, 0);
        add(0, 0, 0, ST_RUN, 0);
        // T6: reset mid-DRAIN, then mid-INIT at addr 1
        add(0, 1, 0, ST_FLUSH, 0);
        add(0, 0, 0, ST_DRAIN, 0);
        add(1, 0, 0, ST_IDLE, 0);
        add(0, 1, 0, ST_INIT, 0);
        add(0, 0, 0, ST_INIT, 1);
        add(1, 0, 0, ST_IDLE, 0);
        add(0, 0, 0, ST_INIT, 0);
        add(0, 0, 0, ST_INIT, 1);
        add(0, 0, 0, ST_INIT, 2);
        // T4: flush_req seen at addr 2 and 3 is ignored
        add(0, 1, 0, ST_INIT, 3);
        add(0, 1, 0, ST_WARM, 0);
        add(0, 0, 0, ST_WARM, 0);
        add(0, 0, 0, ST_RUN, 0);

        rst = 1'b1;
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rst;
            flush_req = vecs[i].fr;
            rob_empty = vecs[i].re;
            step();
            got = {init_we, init_addr, if_en, id_en, flush, busy, ready};
            check($sformatf("vec%0d", i), int'(got), int'(expect_outs(vecs[i].st, vecs[i].addr)));
        end

        // T1 edge timing measured from the first edge with rst low
        rst = 1'b1; flush_req = 1'b0; rob_empty = 1'b0;
        step(); step();
        check("reset_if_en", int'(if_en), 0);
        rst = 1'b0;
        first_if = 0;
        first_id = 0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (if_en && first_if == 0) first_if = e;
            if (id_en && first_id == 0) first_id = e;
        end
        check("first_if_edge", first_if, 5);
        check("first_id_edge", first_id, 7);

        // T3 timing: if_en returns 5 cycles after flush rose
        rob_empty = 1'b1;
        flush_req = 1'b1;
        step();
        check("flush_rise", int'(flush), 1);
        flush_req = 1'b0;
        first_if = 0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (if_en && first_if == 0) first_if = e;
        end
        check("if_return_delay", first_if, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
